alu_share_arbiter: RTL

- Sequences one shared combinational 8-bit ALU (3-bit opcode, operands A/B, result Y) between two requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block registers the operands into the ALU, captures Y one cycle later, and returns the result to the granted requester.
- Sits between the requester blocks and the ALU instance; the ALU itself is unchanged.

---
 rtl/alu_share_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Time-shares one combinational ALU between two valid/ready requesters.
//            Define ALU_SHARE_ARBITER_FIXED_PRIO_EN for fixed priority (requester 0 wins).
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [OP_W-1:0]   req0_opcode,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [OP_W-1:0]   req1_opcode,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic [1:0]        resp_valid,
   input  logic [1:0]        resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic [OP_W-1:0]   alu_opcode,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_y,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                grant_q, grant_d;
   logic [DATA_W-1:0]   resp_data_q, resp_data_d;
   logic [OP_W-1:0]     alu_opcode_q, alu_opcode_d;
   logic [DATA_W-1:0]   alu_a_q, alu_a_d;
   logic [DATA_W-1:0]   alu_b_q, alu_b_d;
   logic                sel;

`ifdef ALU_SHARE_ARBITER_FIXED_PRIO_EN
   always_comb begin
      sel = (req_valid == 2'b10);
   end
`else
   logic rr_ptr_q, rr_ptr_d;

   always_comb begin
      case (req_valid)
         2'b10:   sel = 1'b1;
         2'b11:   sel = rr_ptr_q;
         default: sel = 1'b0;
      endcase
   end

   // Pointer moves only when a response completes, so the last-served loses ties.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (state_q == RESP && resp_ready[grant_q]) begin
         rr_ptr_d = ~grant_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      resp_data_d  = resp_data_q;
      alu_opcode_d = alu_opcode_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      req_ready    = 2'b00;
      resp_valid   = 2'b00;
      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready[sel] = 1'b1;
               grant_d        = sel;
               alu_opcode_d   = sel ? req1_opcode : req0_opcode;
               alu_a_d        = sel ? req1_a      : req0_a;
               alu_b_d        = sel ? req1_b      : req0_b;
               state_d        = EXEC;
            end
         end
         EXEC: begin
            resp_data_d = alu_y;
            state_d     = RESP;
         end
         RESP: begin
            resp_valid[grant_q] = 1'b1;
            if (resp_ready[grant_q]) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= 1'b0;
         resp_data_q  <= '0;
         alu_opcode_q <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         resp_data_q  <= resp_data_d;
         alu_opcode_q <= alu_opcode_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
      end
   end

   assign resp_data  = resp_data_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire
